// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with a registered one-hot grant and a bounded hold time.
// The release input is named release_i because release is a reserved SystemVerilog keyword.
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic [7:0] grant,
  output logic       busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d, idx_q, idx_d, win;
  logic [3:0] hold_q, hold_d;
  logic [7:0] grant_q, grant_d;
  logic       busy_q, busy_d, done;
  always_comb begin
    win = ptr_q;
    // Scan from the far end so the first requester after ptr is the last one written.
    for (int k = 7; k >= 0; k--) if (req[ptr_q + 3'(k)]) win = ptr_q + 3'(k);
    done    = release_i || !req[idx_q] || hold_q == 4'(HOLD_MAX);
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        idx_d   = win;
        grant_d = 8'b1 << win;
        hold_d  = 4'd1;
      end
    end else if (done) begin
      state_d = IDLE;
      grant_d = '0;
      hold_d  = '0;
      ptr_d   = idx_q + 3'd1;
    end else begin
      hold_d  = hold_q + 4'd1;
    end
    busy_d = |grant_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end
  assign grant = grant_q;
  assign busy  = busy_q;
endmodule
